execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the 5-stage RV32I pipeline, sitting between decode and memory. It takes decoded one-hot ALU/opcode controls, operands, immediate and PC, and computes the ALU result, the rd write-back value, branch/jump resolution and the next PC. All results are registered into the EX/MEM boundary, with stall/flush propagation.

## Interface
- AWIDTH, 5: register address width
- DWIDTH, 32: data width
- PC_WIDTH, 32: PC width
- FUNCT_WIDTH, 3: funct3 width
- `ALU_WIDTH` = 14, one-hot, bit order: ADD, SUB, SLT, SLTU, XOR, OR, AND, SLL, SRL, SRA, EQ, NEQ, GE, GEU (bit 0..13)
- `OPCODE_WIDTH` = 11, one-hot, bit order: RTYPE, ITYPE, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, FENCE (bit 0..10)
- ex_clk  in  1  clock, rising edge
- ex_rst  in  1  asynchronous, active-low reset
- ex_i_alu / ex_o_alu  in/out  ALU_WIDTH  ALU op; output is registered copy
- ex_i_opcode / ex_o_opcode  in/out  OPCODE_WIDTH  instruction class; registered copy
- ex_i_addr_rs1, ex_i_addr_rs2, ex_i_addr_rd / ex_o_*  in/out  AWIDTH  register addresses; registered copies
- ex_i_data_rs1, ex_i_data_rs2 / ex_o_*  in/out  DWIDTH  operand values; registered copies (rs2 feeds store data)
- ex_i_funct3 / ex_o_funct3  in/out  FUNCT_WIDTH  funct3; registered copy
- ex_i_imm / ex_o_imm  in/out  DWIDTH  decoded immediate (LUI imm already shifted <<12); registered copy
- ex_i_pc / ex_o_pc  in/out  PC_WIDTH  instruction PC; registered copy
- ex_i_ce / ex_o_ce  in/out  1  stage enable in; out = registered ce AND NOT ex_o_stall
- ex_i_stall / ex_o_stall  in/out  1  stall from downstream; out = ex_i_stall OR ex_stall_from_alu (combinational)
- ex_i_flush / ex_o_flush  in/out  1  flush in; out = ex_i_flush OR ex_o_change_pc (combinational)
- ex_o_alu_value  out  DWIDTH  registered raw ALU result
- ex_o_data_rd  out  DWIDTH  registered rd write-back value
- ex_next_pc  out  PC_WIDTH  registered next PC
- ex_o_change_pc  out  1  registered: taken branch or jump
- ex_o_we_reg  out  1  registered rd write enable
- ex_o_valid  out  1  registered: instruction in EX/MEM is valid
- ex_stall_from_alu  out  1  ALU-originated stall; constant 0 (single-cycle ALU)

## Operation
- Operand A: ex_i_pc for AUIPC/JAL, else ex_i_data_rs1. Operand B: ex_i_data_rs2 for RTYPE/BRANCH, else ex_i_imm.
- ALU: ADD/SUB wrap mod 2^32; SLT/GE signed, SLTU/GEU unsigned; EQ/NEQ equality; comparisons yield 32'd1/32'd0; shifts use B[4:0], SRA arithmetic. No bit set -> 0.
- data_rd: LUI -> imm; AUIPC -> pc+imm; JAL/JALR -> pc+4; else ALU result.
- Branch taken: BRANCH and ALU result bit0 = 1 (SLT/SLTU serve BLT/BLTU).
- next_pc: taken branch or JAL -> pc+imm; JALR -> (rs1+imm) & ~1; else pc+4. change_pc = taken branch OR JAL OR JALR.
- we_reg = 1 for RTYPE, ITYPE, LOAD, JAL, JALR, LUI, AUIPC; 0 otherwise.

## Timing
- Reset (ex_rst=0, async): every registered output 0.
- Edge with ex_i_stall=1: all registers hold.
- Edge with ex_i_flush=1 (not stalled): valid, ce, we_reg, change_pc cleared to 0; other regs may load.
- Edge with ex_i_ce=1, no stall/flush: all outputs load; visible one cycle after inputs (latency 1).
- Edge with ex_i_ce=0, no stall/flush: valid, ce, we_reg, change_pc cleared; data regs hold.
- Stall and flush together: stall wins (hold).

## Configuration
- EXECUTE_RD0_GUARD_EN defined: we_reg forced 0 when ex_i_addr_rd = 0. Undefined: we_reg purely per opcode.

## Test plan
- Reset, then ADD 10+20 -> alu_value/data_rd 0x1E, we 1, valid 1, change_pc 0, next_pc 0x1004 (pc 0x1000); SUB 50-30 -> 0x14.
- SLL 1,3 -> 0x8; SRA 0xFFFFFFF0,2 -> 0xFFFFFFFC; SLTU 1,0xFFFFFFFF -> 1, SLT same -> 0.
- LUI imm 0xABCD1000 -> data_rd 0xABCD1000; AUIPC pc 0x2000 imm 0x100 -> data_rd 0x2100.
- JAL pc 0x3000 imm 0x10 -> next_pc 0x3010, data_rd 0x3004, change_pc 1, ex_o_flush 1; JALR rs1 0x101 imm 0 -> next_pc 0x100.
- BEQ 10,10 imm 4 pc 0x4000 -> next_pc 0x4004, change_pc 1, we 0; BEQ 10,11 -> change_pc 0, next_pc 0x4004.
- Stall held 2 cycles with changing inputs -> outputs unchanged, ex_o_ce 0; flush -> valid/we/change_pc 0; mid-run reset -> all 0.

Source files
------------

// File: rtl/execute_stage.sv
// RV32I execute stage: ALU, branch/jump resolution, EX/MEM registers.
// Option: EXECUTE_RD0_GUARD_EN suppresses rd write-back when rd is x0.
module execute_stage #(
  parameter int AWIDTH       = 5,
  parameter int DWIDTH       = 32,
  parameter int PC_WIDTH     = 32,
  parameter int FUNCT_WIDTH  = 3,
  parameter int ALU_WIDTH    = 14,
  parameter int OPCODE_WIDTH = 11
) (
  input  logic                    ex_clk,
  input  logic                    ex_rst,
  input  logic [ALU_WIDTH-1:0]    ex_i_alu,
  output logic [ALU_WIDTH-1:0]    ex_o_alu,
  input  logic [OPCODE_WIDTH-1:0] ex_i_opcode,
  output logic [OPCODE_WIDTH-1:0] ex_o_opcode,
  input  logic [AWIDTH-1:0]       ex_i_addr_rs1,
  output logic [AWIDTH-1:0]       ex_o_addr_rs1,
  input  logic [AWIDTH-1:0]       ex_i_addr_rs2,
  output logic [AWIDTH-1:0]       ex_o_addr_rs2,
  input  logic [AWIDTH-1:0]       ex_i_addr_rd,
  output logic [AWIDTH-1:0]       ex_o_addr_rd,
  input  logic [DWIDTH-1:0]       ex_i_data_rs1,
  output logic [DWIDTH-1:0]       ex_o_data_rs1,
  input  logic [DWIDTH-1:0]       ex_i_data_rs2,
  output logic [DWIDTH-1:0]       ex_o_data_rs2,
  input  logic [FUNCT_WIDTH-1:0]  ex_i_funct3,
  output logic [FUNCT_WIDTH-1:0]  ex_o_funct3,
  input  logic [DWIDTH-1:0]       ex_i_imm,
  output logic [DWIDTH-1:0]       ex_o_imm,
  input  logic [PC_WIDTH-1:0]     ex_i_pc,
  output logic [PC_WIDTH-1:0]     ex_o_pc,
  input  logic                    ex_i_ce,
  output logic                    ex_o_ce,
  input  logic                    ex_i_stall,
  output logic                    ex_o_stall,
  input  logic                    ex_i_flush,
  output logic                    ex_o_flush,
  output logic [DWIDTH-1:0]       ex_o_alu_value,
  output logic [DWIDTH-1:0]       ex_o_data_rd,
  output logic [PC_WIDTH-1:0]     ex_next_pc,
  output logic                    ex_o_change_pc,
  output logic                    ex_o_we_reg,
  output logic                    ex_o_valid,
  output logic                    ex_stall_from_alu
);

  localparam int A_ADD  = 0;
  localparam int A_SUB  = 1;
  localparam int A_SLT  = 2;
  localparam int A_SLTU = 3;
  localparam int A_XOR  = 4;
  localparam int A_OR   = 5;
  localparam int A_AND  = 6;
  localparam int A_SLL  = 7;
  localparam int A_SRL  = 8;
  localparam int A_SRA  = 9;
  localparam int A_EQ   = 10;
  localparam int A_NEQ  = 11;
  localparam int A_GE   = 12;
  localparam int A_GEU  = 13;

  localparam int O_RTYPE  = 0;
  localparam int O_ITYPE  = 1;
  localparam int O_LOAD   = 2;
  localparam int O_BRANCH = 4;
  localparam int O_JAL    = 5;
  localparam int O_JALR   = 6;
  localparam int O_LUI    = 7;
  localparam int O_AUIPC  = 8;

  localparam logic [DWIDTH-1:0] ZPAD = '0;

  logic [DWIDTH-1:0]   op_a;
  logic [DWIDTH-1:0]   op_b;
  logic [DWIDTH-1:0]   alu_res;
  logic [DWIDTH-1:0]   rd_val;
  logic [DWIDTH-1:0]   jalr_sum;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] pc_imm;
  logic [PC_WIDTH-1:0] npc;
  logic                taken;
  logic                chg;
  logic                we;
  logic                ce_q;

  assign ex_stall_from_alu = 1'b0;
  assign ex_o_stall = ex_i_stall | ex_stall_from_alu;
  assign ex_o_flush = ex_i_flush | ex_o_change_pc;
  assign ex_o_ce    = ce_q & ~ex_o_stall;

  assign op_a = (ex_i_opcode[O_AUIPC] | ex_i_opcode[O_JAL]) ?
                DWIDTH'(ex_i_pc) : ex_i_data_rs1;
  assign op_b = (ex_i_opcode[O_RTYPE] | ex_i_opcode[O_BRANCH]) ?
                ex_i_data_rs2 : ex_i_imm;

  always_comb begin
    alu_res = '0;
    unique case (1'b1)
      ex_i_alu[A_ADD]:  alu_res = op_a + op_b;
      ex_i_alu[A_SUB]:  alu_res = op_a - op_b;
      ex_i_alu[A_SLT]:  alu_res = {ZPAD[DWIDTH-1:1],
                                   $signed(op_a) < $signed(op_b)};
      ex_i_alu[A_SLTU]: alu_res = {ZPAD[DWIDTH-1:1], op_a < op_b};
      ex_i_alu[A_XOR]:  alu_res = op_a ^ op_b;
      ex_i_alu[A_OR]:   alu_res = op_a | op_b;
      ex_i_alu[A_AND]:  alu_res = op_a & op_b;
      ex_i_alu[A_SLL]:  alu_res = op_a << op_b[4:0];
      ex_i_alu[A_SRL]:  alu_res = op_a >> op_b[4:0];
      ex_i_alu[A_SRA]:  alu_res = $signed(op_a) >>> op_b[4:0];
      ex_i_alu[A_EQ]:   alu_res = {ZPAD[DWIDTH-1:1], op_a == op_b};
      ex_i_alu[A_NEQ]:  alu_res = {ZPAD[DWIDTH-1:1], op_a != op_b};
      ex_i_alu[A_GE]:   alu_res = {ZPAD[DWIDTH-1:1],
                                   $signed(op_a) >= $signed(op_b)};
      ex_i_alu[A_GEU]:  alu_res = {ZPAD[DWIDTH-1:1], op_a >= op_b};
      default:          alu_res = '0;
    endcase
  end

  assign pc_plus4 = ex_i_pc + PC_WIDTH'(4);
  assign pc_imm   = ex_i_pc + PC_WIDTH'(ex_i_imm);
  assign jalr_sum = ex_i_data_rs1 + ex_i_imm;
  assign taken    = ex_i_opcode[O_BRANCH] & alu_res[0];
  assign chg      = taken | ex_i_opcode[O_JAL] | ex_i_opcode[O_JALR];

  always_comb begin
    npc = pc_plus4;
    unique case (1'b1)
      ex_i_opcode[O_JALR]: npc = PC_WIDTH'(jalr_sum) & ~PC_WIDTH'(1);
      taken,
      ex_i_opcode[O_JAL]:  npc = pc_imm;
      default:             npc = pc_plus4;
    endcase
  end

  always_comb begin
    rd_val = alu_res;
    unique case (1'b1)
      ex_i_opcode[O_LUI]:   rd_val = ex_i_imm;
      ex_i_opcode[O_AUIPC]: rd_val = DWIDTH'(pc_imm);
      ex_i_opcode[O_JAL],
      ex_i_opcode[O_JALR]:  rd_val = DWIDTH'(pc_plus4);
      default:              rd_val = alu_res;
    endcase
  end

`ifdef EXECUTE_RD0_GUARD_EN
  assign we = (ex_i_addr_rd != '0) &
              (ex_i_opcode[O_RTYPE] | ex_i_opcode[O_ITYPE] |
               ex_i_opcode[O_LOAD]  | ex_i_opcode[O_JAL]   |
               ex_i_opcode[O_JALR]  | ex_i_opcode[O_LUI]   |
               ex_i_opcode[O_AUIPC]);
`else
  assign we = ex_i_opcode[O_RTYPE] | ex_i_opcode[O_ITYPE] |
              ex_i_opcode[O_LOAD]  | ex_i_opcode[O_JAL]   |
              ex_i_opcode[O_JALR]  | ex_i_opcode[O_LUI]   |
              ex_i_opcode[O_AUIPC];
`endif

  always_ff @(posedge ex_clk or negedge ex_rst) begin
    if (!ex_rst) begin
      ex_o_alu       <= '0;
      ex_o_opcode    <= '0;
      ex_o_addr_rs1  <= '0;
      ex_o_addr_rs2  <= '0;
      ex_o_addr_rd   <= '0;
      ex_o_data_rs1  <= '0;
      ex_o_data_rs2  <= '0;
      ex_o_funct3    <= '0;
      ex_o_imm       <= '0;
      ex_o_pc        <= '0;
      ex_o_alu_value <= '0;
      ex_o_data_rd   <= '0;
      ex_next_pc     <= '0;
      ex_o_change_pc <= 1'b0;
      ex_o_we_reg    <= 1'b0;
      ex_o_valid     <= 1'b0;
      ce_q           <= 1'b0;
    end else if (!ex_o_stall) begin
      // Bubble on flush or idle: data regs hold, control bits drop
      if (ex_i_flush || !ex_i_ce) begin
        ex_o_change_pc <= 1'b0;
        ex_o_we_reg    <= 1'b0;
        ex_o_valid     <= 1'b0;
        ce_q           <= 1'b0;
      end else begin
        ex_o_alu       <= ex_i_alu;
        ex_o_opcode    <= ex_i_opcode;
        ex_o_addr_rs1  <= ex_i_addr_rs1;
        ex_o_addr_rs2  <= ex_i_addr_rs2;
        ex_o_addr_rd   <= ex_i_addr_rd;
        ex_o_data_rs1  <= ex_i_data_rs1;
        ex_o_data_rs2  <= ex_i_data_rs2;
        ex_o_funct3    <= ex_i_funct3;
        ex_o_imm       <= ex_i_imm;
        ex_o_pc        <= ex_i_pc;
        ex_o_alu_value <= alu_res;
        ex_o_data_rd   <= rd_val;
        ex_next_pc     <= npc;
        ex_o_change_pc <= chg;
        ex_o_we_reg    <= we;
        ex_o_valid     <= 1'b1;
        ce_q           <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed plan vectors,
// random traffic against a behavioural model, stall/flush/reset.
module tb_execute_stage;

  localparam logic [13:0] ADD  = 14'h0001;
  localparam logic [13:0] SUB  = 14'h0002;
  localparam logic [13:0] SLT  = 14'h0004;
  localparam logic [13:0] SLTU = 14'h0008;
  localparam logic [13:0] SLL  = 14'h0080;
  localparam logic [13:0] SRA  = 14'h0200;
  localparam logic [13:0] EQ   = 14'h0400;

  localparam logic [10:0] RT    = 11'h001;
  localparam logic [10:0] IT    = 11'h002;
  localparam logic [10:0] BR    = 11'h010;
  localparam logic [10:0] JAL   = 11'h020;
  localparam logic [10:0] JALR  = 11'h040;
  localparam logic [10:0] LUI   = 11'h080;
  localparam logic [10:0] AUIPC = 11'h100;

  logic        ex_clk = 1'b0;
  logic        ex_rst = 1'b0;
  logic [13:0] ex_i_alu = '0;
  logic [13:0] ex_o_alu;
  logic [10:0] ex_i_opcode = '0;
  logic [10:0] ex_o_opcode;
  logic [4:0]  ex_i_addr_rs1 = '0, ex_i_addr_rs2 = '0, ex_i_addr_rd = '0;
  logic [4:0]  ex_o_addr_rs1, ex_o_addr_rs2, ex_o_addr_rd;
  logic [31:0] ex_i_data_rs1 = '0, ex_i_data_rs2 = '0;
  logic [31:0] ex_o_data_rs1, ex_o_data_rs2;
  logic [2:0]  ex_i_funct3 = '0;
  logic [2:0]  ex_o_funct3;
  logic [31:0] ex_i_imm = '0, ex_o_imm;
  logic [31:0] ex_i_pc = '0, ex_o_pc;
  logic        ex_i_ce = 1'b0, ex_o_ce;
  logic        ex_i_stall = 1'b0, ex_o_stall;
  logic        ex_i_flush = 1'b0, ex_o_flush;
  logic [31:0] ex_o_alu_value, ex_o_data_rd, ex_next_pc;
  logic        ex_o_change_pc, ex_o_we_reg, ex_o_valid;
  logic        ex_stall_from_alu;

  int total = 0;
  int bad = 0;

  execute_stage dut (
    .ex_clk(ex_clk), .ex_rst(ex_rst),
    .ex_i_alu(ex_i_alu), .ex_o_alu(ex_o_alu),
    .ex_i_opcode(ex_i_opcode), .ex_o_opcode(ex_o_opcode),
    .ex_i_addr_rs1(ex_i_addr_rs1), .ex_o_addr_rs1(ex_o_addr_rs1),
    .ex_i_addr_rs2(ex_i_addr_rs2), .ex_o_addr_rs2(ex_o_addr_rs2),
    .ex_i_addr_rd(ex_i_addr_rd), .ex_o_addr_rd(ex_o_addr_rd),
    .ex_i_data_rs1(ex_i_data_rs1), .ex_o_data_rs1(ex_o_data_rs1),
    .ex_i_data_rs2(ex_i_data_rs2), .ex_o_data_rs2(ex_o_data_rs2),
    .ex_i_funct3(ex_i_funct3), .ex_o_funct3(ex_o_funct3),
    .ex_i_imm(ex_i_imm), .ex_o_imm(ex_o_imm),
    .ex_i_pc(ex_i_pc), .ex_o_pc(ex_o_pc),
    .ex_i_ce(ex_i_ce), .ex_o_ce(ex_o_ce),
    .ex_i_stall(ex_i_stall), .ex_o_stall(ex_o_stall),
    .ex_i_flush(ex_i_flush), .ex_o_flush(ex_o_flush),
    .ex_o_alu_value(ex_o_alu_value), .ex_o_data_rd(ex_o_data_rd),
    .ex_next_pc(ex_next_pc), .ex_o_change_pc(ex_o_change_pc),
    .ex_o_we_reg(ex_o_we_reg), .ex_o_valid(ex_o_valid),
    .ex_stall_from_alu(ex_stall_from_alu)
  );

  always #5 ex_clk = ~ex_clk;

  task automatic step();
    @(posedge ex_clk);
    #1;
  endtask

  task automatic drive(input logic [13:0] a, input logic [10:0] o,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] im, input logic [31:0] p,
                       input logic [4:0] rd);
    ex_i_alu = a; ex_i_opcode = o;
    ex_i_data_rs1 = r1; ex_i_data_rs2 = r2;
    ex_i_imm = im; ex_i_pc = p; ex_i_addr_rd = rd;
    ex_i_addr_rs1 = rd ^ 5'h3; ex_i_addr_rs2 = rd ^ 5'h5;
    ex_i_funct3 = rd[2:0]; ex_i_ce = 1'b1;
  endtask

  // Reference behaviour from the instruction semantics
  function automatic void model(
      input logic [13:0] alu, input logic [10:0] opc,
      input logic [31:0] rs1, input logic [31:0] rs2,
      input logic [31:0] imm, input logic [31:0] pc,
      input logic [4:0] rd,
      output logic [31:0] res, output logic [31:0] drd,
      output logic [31:0] npc, output logic chg, output logic we);
    int k;
    logic [31:0] a, b;
    logic taken;
    k = -1;
    for (int i = 0; i < 14; i++) if (alu[i]) k = i;
    a = (opc == AUIPC || opc == JAL) ? pc : rs1;
    b = (opc == RT || opc == BR) ? rs2 : imm;
    case (k)
      0: res = a + b;
      1: res = a - b;
      2: res = (int'(a) < int'(b)) ? 1 : 0;
      3: res = (a < b) ? 1 : 0;
      4: res = a ^ b;
      5: res = a | b;
      6: res = a & b;
      7: res = a << b[4:0];
      8: res = a >> b[4:0];
      9: res = 32'(int'(a) >>> b[4:0]);
      10: res = (a == b) ? 1 : 0;
      11: res = (a != b) ? 1 : 0;
      12: res = (int'(a) >= int'(b)) ? 1 : 0;
      13: res = (a >= b) ? 1 : 0;
      default: res = 0;
    endcase
    case (opc)
      LUI: drd = imm;
      AUIPC: drd = pc + imm;
      JAL, JALR: drd = pc + 4;
      default: drd = res;
    endcase
    taken = (opc == BR) && res[0];
    if (opc == JALR) npc = (rs1 + imm) & 32'hFFFF_FFFE;
    else if (taken || opc == JAL) npc = pc + imm;
    else npc = pc + 4;
    chg = taken || opc == JAL || opc == JALR;
    we = (opc == RT || opc == IT || opc == 11'h004 || opc == JAL ||
          opc == JALR || opc == LUI || opc == AUIPC);
`ifdef EXECUTE_RD0_GUARD_EN
    if (rd == 0) we = 1'b0;
`endif
  endfunction

  task automatic test_reset();
    ex_rst = 1'b0;
    #2;
    total++;
    if ({ex_o_alu, ex_o_opcode, ex_o_pc, ex_o_alu_value, ex_o_data_rd,
         ex_next_pc, ex_o_imm, ex_o_data_rs1} !== '0) begin
      bad++;
      $display("FAIL reset_data got nonzero alu_value=%h pc=%h",
               ex_o_alu_value, ex_o_pc);
    end
    total++;
    if ({ex_o_valid, ex_o_we_reg, ex_o_change_pc, ex_o_ce} !== 4'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=0000",
               {ex_o_valid, ex_o_we_reg, ex_o_change_pc, ex_o_ce});
    end
    @(negedge ex_clk);
    ex_rst = 1'b1;
    step();
  endtask

  task automatic test_alu();
    logic [13:0] ops [6];
    logic [31:0] a [6];
    logic [31:0] b [6];
    logic [31:0] e [6];
    ops = '{ADD, SUB, SLL, SRA, SLTU, SLT};
    a = '{32'd10, 32'd50, 32'd1, 32'hFFFF_FFF0, 32'd1, 32'd1};
    b = '{32'd20, 32'd30, 32'd3, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    e = '{32'h1E, 32'h14, 32'h8, 32'hFFFF_FFFC, 32'd1, 32'd0};
    for (int i = 0; i < 6; i++) begin
      drive(ops[i], RT, a[i], b[i], 32'h0, 32'h1000, 5'd3);
      step();
      total++;
      if (ex_o_alu_value !== e[i] || ex_o_data_rd !== e[i]) begin
        bad++;
        $display("FAIL alu_%0d got=%h/%h exp=%h", i,
                 ex_o_alu_value, ex_o_data_rd, e[i]);
      end
      total++;
      if ({ex_o_we_reg, ex_o_valid, ex_o_change_pc} !== 3'b110 ||
          ex_next_pc !== 32'h1004) begin
        bad++;
        $display("FAIL alu_ctrl_%0d got=%b npc=%h exp=110 npc=1004", i,
                 {ex_o_we_reg, ex_o_valid, ex_o_change_pc}, ex_next_pc);
      end
    end
  endtask

  task automatic test_upper();
    drive(ADD, LUI, 32'h0, 32'h0, 32'hABCD_1000, 32'h1800, 5'd4);
    step();
    total++;
    if (ex_o_data_rd !== 32'hABCD_1000 || ex_o_we_reg !== 1'b1) begin
      bad++;
      $display("FAIL lui got=%h we=%b exp=abcd1000 we=1",
               ex_o_data_rd, ex_o_we_reg);
    end
    drive(ADD, AUIPC, 32'h55, 32'h0, 32'h100, 32'h2000, 5'd5);
    step();
    total++;
    if (ex_o_data_rd !== 32'h2100) begin
      bad++;
      $display("FAIL auipc got=%h exp=2100", ex_o_data_rd);
    end
  endtask

  task automatic test_jump();
    drive(ADD, JAL, 32'h0, 32'h0, 32'h10, 32'h3000, 5'd1);
    step();
    total++;
    if (ex_next_pc !== 32'h3010 || ex_o_data_rd !== 32'h3004) begin
      bad++;
      $display("FAIL jal got npc=%h rd=%h exp npc=3010 rd=3004",
               ex_next_pc, ex_o_data_rd);
    end
    total++;
    if ({ex_o_change_pc, ex_o_flush, ex_o_we_reg} !== 3'b111) begin
      bad++;
      $display("FAIL jal_ctrl got=%b exp=111",
               {ex_o_change_pc, ex_o_flush, ex_o_we_reg});
    end
    drive(ADD, JALR, 32'h101, 32'h0, 32'h0, 32'h3100, 5'd1);
    step();
    total++;
    if (ex_next_pc !== 32'h100 || ex_o_data_rd !== 32'h3104 ||
        ex_o_change_pc !== 1'b1) begin
      bad++;
      $display("FAIL jalr got npc=%h rd=%h chg=%b exp 100/3104/1",
               ex_next_pc, ex_o_data_rd, ex_o_change_pc);
    end
  endtask

  task automatic test_branch();
    drive(EQ, BR, 32'd10, 32'd10, 32'd4, 32'h4000, 5'd0);
    step();
    total++;
    if (ex_next_pc !== 32'h4004 || ex_o_change_pc !== 1'b1 ||
        ex_o_we_reg !== 1'b0) begin
      bad++;
      $display("FAIL beq_taken got npc=%h chg=%b we=%b exp 4004/1/0",
               ex_next_pc, ex_o_change_pc, ex_o_we_reg);
    end
    drive(EQ, BR, 32'd10, 32'd11, 32'd4, 32'h4000, 5'd0);
    step();
    total++;
    if (ex_next_pc !== 32'h4004 || ex_o_change_pc !== 1'b0 ||
        ex_o_flush !== 1'b0) begin
      bad++;
      $display("FAIL beq_not got npc=%h chg=%b fl=%b exp 4004/0/0",
               ex_next_pc, ex_o_change_pc, ex_o_flush);
    end
    drive(SLT, BR, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h4100, 5'd0);
    step();
    total++;
    if (ex_next_pc !== 32'h4140 || ex_o_change_pc !== 1'b1) begin
      bad++;
      $display("FAIL blt got npc=%h chg=%b exp 4140/1",
               ex_next_pc, ex_o_change_pc);
    end
  endtask

  task automatic test_random();
    logic [13:0] a;
    logic [10:0] o;
    logic [31:0] r1, r2, im, p, er, ed, en;
    logic [4:0]  rd;
    logic        ec, ew;
    for (int n = 0; n < 300; n++) begin
      a = 14'd1 << $urandom_range(0, 13);
      o = 11'd1 << $urandom_range(0, 10);
      r1 = $urandom;
      r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
      im = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
      p = {$urandom, 2'b00} & 32'hFFFF_FFFC;
      rd = 5'($urandom_range(0, 31));
      drive(a, o, r1, r2, im, p, rd);
      model(a, o, r1, r2, im, p, rd, er, ed, en, ec, ew);
      step();
      total++;
      if (ex_o_alu_value !== er || ex_o_data_rd !== ed ||
          ex_next_pc !== en) begin
        bad++;
        $display("FAIL rand_%0d alu=%h op=%h got %h/%h/%h exp %h/%h/%h",
                 n, a, o, ex_o_alu_value, ex_o_data_rd, ex_next_pc,
                 er, ed, en);
      end
      total++;
      if ({ex_o_change_pc, ex_o_we_reg, ex_o_valid, ex_o_ce} !==
          {ec, ew, 2'b11} || ex_o_pc !== p || ex_o_addr_rd !== rd ||
          ex_o_data_rs2 !== r2) begin
        bad++;
        $display("FAIL rand_ctrl_%0d got=%b exp=%b pc=%h rd=%0d",
                 n, {ex_o_change_pc, ex_o_we_reg, ex_o_valid, ex_o_ce},
                 {ec, ew, 2'b11}, ex_o_pc, ex_o_addr_rd);
      end
    end
  endtask

  task automatic test_stall_flush();
    drive(ADD, RT, 32'd7, 32'd8, 32'h0, 32'h5000, 5'd9);
    step();
    ex_i_stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      drive(SUB, JAL, $urandom, $urandom, 32'h20, 32'h6000 + c, 5'd2);
      ex_i_flush = (c == 1);
      step();
      total++;
      if (ex_o_alu_value !== 32'd15 || ex_o_pc !== 32'h5000 ||
          ex_o_valid !== 1'b1 || ex_o_change_pc !== 1'b0 ||
          ex_o_addr_rd !== 5'd9) begin
        bad++;
        $display("FAIL stall_hold_%0d got alu=%h pc=%h v=%b exp 0f/5000/1",
                 c, ex_o_alu_value, ex_o_pc, ex_o_valid);
      end
      total++;
      if (ex_o_ce !== 1'b0 || ex_o_stall !== 1'b1) begin
        bad++;
        $display("FAIL stall_ce_%0d got ce=%b st=%b exp 0/1",
                 c, ex_o_ce, ex_o_stall);
      end
    end
    ex_i_stall = 1'b0;
    ex_i_flush = 1'b1;
    drive(ADD, JAL, 32'd1, 32'd2, 32'h8, 32'h7000, 5'd3);
    step();
    total++;
    if ({ex_o_valid, ex_o_we_reg, ex_o_change_pc, ex_o_ce} !== 4'b0 ||
        ex_o_flush !== 1'b1) begin
      bad++;
      $display("FAIL flush got=%b fl=%b exp=0000 fl=1",
               {ex_o_valid, ex_o_we_reg, ex_o_change_pc, ex_o_ce},
               ex_o_flush);
    end
    ex_i_flush = 1'b0;
    drive(ADD, IT, 32'd100, 32'd0, 32'd23, 32'h8000, 5'd6);
    step();
    total++;
    if (ex_o_alu_value !== 32'd123 || ex_o_valid !== 1'b1) begin
      bad++;
      $display("FAIL after_flush got=%h v=%b exp=7b v=1",
               ex_o_alu_value, ex_o_valid);
    end
    drive(SUB, RT, 32'd9, 32'd1, 32'd0, 32'h9000, 5'd7);
    ex_i_ce = 1'b0;
    step();
    total++;
    if (ex_o_valid !== 1'b0 || ex_o_we_reg !== 1'b0 ||
        ex_o_alu_value !== 32'd123 || ex_o_pc !== 32'h8000) begin
      bad++;
      $display("FAIL ce_low got v=%b we=%b alu=%h pc=%h exp 0/0/7b/8000",
               ex_o_valid, ex_o_we_reg, ex_o_alu_value, ex_o_pc);
    end
  endtask

  task automatic test_mid_reset();
    drive(ADD, JAL, 32'd0, 32'd0, 32'h40, 32'hA000, 5'd8);
    step();
    #2;
    ex_rst = 1'b0;
    #1;
    total++;
    if ({ex_o_valid, ex_o_we_reg, ex_o_change_pc, ex_o_ce} !== 4'b0 ||
        ex_next_pc !== '0 || ex_o_data_rd !== '0 || ex_o_pc !== '0) begin
      bad++;
      $display("FAIL mid_reset got ctrl=%b npc=%h rd=%h",
               {ex_o_valid, ex_o_we_reg, ex_o_change_pc, ex_o_ce},
               ex_next_pc, ex_o_data_rd);
    end
    @(negedge ex_clk);
    ex_rst = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_upper();
    test_jump();
    test_branch();
    test_random();
    test_stall_flush();
    test_mid_reset();
    total++;
    if (ex_stall_from_alu !== 1'b0) begin
      bad++;
      $display("FAIL stall_from_alu got=%b exp=0", ex_stall_from_alu);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
